micro_sequencer: RTL
====================

# micro_sequencer

Micro-program sequencer for the matrix-multiplication core. It owns the micro-program counter that addresses the combinational `microcode` memory (driving its `reg_out` input), and consumes that memory's `condition`, `BT` and `jump_addr` fields to compute the next address. It registers the 51-bit `OPs` control word into `ops_q`, which drives the datapath, and provides a start/done handshake to the host controller.

## Interface
Parameters:
- `AW`, 16: micro-address width.
- `OPW`, 51: control-word width.
- `START_ADDR`, 16'h0000: entry address loaded on `start`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: single-cycle pulse that begins program execution; ignored unless IDLE.
- `z_flag`, input, 1: zero flag from the datapath, sampled in the same cycle as the micro-word.
- `mem_rdy`, input, 1: memory/core-ready flag for wait micro-ops.
- `upc`, output, AW: micro-PC; connects to microcode `reg_out`.
- `condition`, input, 2: from microcode.
- `BT`, input, 1: branch-type bit from microcode.
- `jump_addr`, input, AW: branch target from microcode.
- `OPs`, input, OPW: control word from microcode.
- `ops_q`, output, OPW: registered control word to the datapath.
- `busy`, output, 1: high in RUN or WAIT.
- `done`, output, 1: one-cycle pulse when the program halts.

## Operation
- States: IDLE, RUN, WAIT.
- Reset values: state IDLE; `upc` = 0; `ops_q` = 0; `busy` = 0; `done` = 0; return register = 0.
- IDLE: `ops_q` holds 0.
  - On `start`: `upc` <= START_ADDR, state RUN.
- RUN: each cycle, `ops_q` <= `OPs`, and the next `upc` is chosen as follows.
  - `BT`=0: `upc`+1 (but see Configuration).
  - `BT`=1, cond 00: `jump_addr`.
  - `BT`=1, cond 01: `z_flag` ? `jump_addr` : `upc`+1.
  - `BT`=1, cond 10: `!z_flag` ? `jump_addr` : `upc`+1.
  - `BT`=1, cond 11, `mem_rdy`=1: `jump_addr`.
  - `BT`=1, cond 11, `mem_rdy`=0: `upc` held, state WAIT.
  - Halt: `BT`=1, cond 00 and `jump_addr`==`upc`. Then `done` = 1 for one cycle, state IDLE, `upc` <= 0, `ops_q` <= `OPs` of the halt word.
- WAIT: `ops_q` <= 0 each cycle, so side effects are not repeated. `upc` is held.
  - When `mem_rdy`=1: `upc` <= `jump_addr`, state RUN.
- Arithmetic: `upc`+1 is modulo 2^AW, so 16'hFFFF wraps to 16'h0000.
- `start` while busy: ignored.
- Asynchronous reset mid-program: immediate return to reset values, with no `done` pulse.

## Timing
- `start` in cycle N puts `upc`=START_ADDR in cycle N+1.
- The word at address A appears on `ops_q` one cycle after `upc`=A.
- Branch penalty: none. The next address is resolved in the same cycle, because microcode is combinational.
- `done` is asserted in the cycle after the halt word is presented on `upc`, coincident with `busy` falling.
- WAIT exits with `upc`=`jump_addr` on the edge where `mem_rdy`=1 is sampled.

## Configuration
- `MICRO_SEQ_CALL_EN` defined: adds a one-entry return register (AW bits). These encodings apply only while `BT`=0.
  - `BT`=0, cond 01 is CALL: ret <= `upc`+1, `upc` <= `jump_addr`.
  - `BT`=0, cond 10 is RET: `upc` <= ret.
  - `BT`=0, cond 00 or 11: sequential.
- `MICRO_SEQ_CALL_EN` undefined: `BT`=0 is always sequential regardless of `condition`, and no return register is built.

## Structure
- Shared package `micro_pkg` holds:
  - State enum: IDLE, RUN, WAIT.
  - Condition encodings: COND_ALWAYS=2'b00, COND_Z=2'b01, COND_NZ=2'b10, COND_WAIT=2'b11.
  - CALL/RET aliases.
  - AW and OPW defaults.
- One sub-module, `micro_next_addr`: combinational next-address and branch-decision logic. State and registers stay in `micro_sequencer`.

## Test plan
- Straight line: reset, pulse `start`, with words 0..3 having `BT`=0 and word 4 the halt (`BT`=1, cond 00, jump 4). Expect `upc` 0,1,2,3,4, then `done` for one cycle, `busy` low, and `upc` back to 0.
- Conditional: word 2 has `BT`=1, cond 01, jump 7. With `z_flag`=1, expect `upc` 2→7. Rerun with `z_flag`=0 and expect 2→3. Repeat with cond 10 and expect the inverse.
- Wait: word 1 has cond 11, jump 5. Hold `mem_rdy`=0 for 3 cycles: expect `upc`=1 held and `ops_q`=0 during WAIT. Raise `mem_rdy`: expect `upc`=5 on the next cycle.
- Wrap and start-ignore: START_ADDR=16'hFFFF. Expect `upc` FFFF→0000. A second `start` while `busy` leaves the sequence unchanged.
- Reset mid-run: deassert `rst_n` at `upc`=3. Expect `upc`=0, `ops_q`=0, `busy`=0 immediately, with no `done`.
- Call/return (with `MICRO_SEQ_CALL_EN`): CALL at 2 to 10, RET at 11. Expect `upc` 2,10,11,3.

Source files
------------

// File: rtl/micro_sequencer_pkg.sv
// micro_sequencer_pkg.sv
// Shared types and constants for the micro-program sequencer: state
// encoding, microcode condition-field encodings and default widths.
// The CALL/RET aliases only take effect when MICRO_SEQ_CALL_EN is defined.

package micro_pkg;

    localparam int DEF_AW  = 16;
    localparam int DEF_OPW = 51;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WAIT = 2'b10
    } state_t;

    // Condition field meaning when BT=1
    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_NZ     = 2'b10;
    localparam logic [1:0] COND_WAIT   = 2'b11;

    // Condition field meaning when BT=0 (subroutine support build only)
    localparam logic [1:0] COND_CALL   = 2'b01;
    localparam logic [1:0] COND_RET    = 2'b10;

endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if.sv
// Bundles the host handshake, datapath flags and the microcode memory
// fields seen by the sequencer. The master side is the sequencer itself;
// the slave side is the surrounding core (host, datapath, microcode ROM).

interface micro_sequencer_if #(
    parameter int AW  = 16,
    parameter int OPW = 51
);
    // host handshake
    logic           start;
    logic           busy;
    logic           done;
    // datapath flags
    logic           z_flag;
    logic           mem_rdy;
    // microcode memory
    logic [AW-1:0]  upc;
    logic [1:0]     condition;
    logic           BT;
    logic [AW-1:0]  jump_addr;
    logic [OPW-1:0] OPs;
    // registered control word to the datapath
    logic [OPW-1:0] ops_q;

    modport master (
        input  start, z_flag, mem_rdy, condition, BT, jump_addr, OPs,
        output upc, ops_q, busy, done
    );

    modport slave (
        output start, z_flag, mem_rdy, condition, BT, jump_addr, OPs,
        input  upc, ops_q, busy, done
    );
endinterface

// File: rtl/micro_sequencer_next_addr.sv
// micro_sequencer_next_addr.sv
// Combinational next-address and branch decision for the micro-PC.
// Reports halt (unconditional jump to itself) and wait-stall separately
// so the sequencer FSM can change state; it holds no state of its own.
// MICRO_SEQ_CALL_EN adds CALL/RET decoding on BT=0 words.

module micro_next_addr
    import micro_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic [AW-1:0] upc,
    input  logic [1:0]    condition,
    input  logic          bt,
    input  logic [AW-1:0] jump_addr,
    input  logic          z_flag,
    input  logic          mem_rdy,
`ifdef MICRO_SEQ_CALL_EN
    input  logic [AW-1:0] ret_addr,
    output logic          push_ret,
`endif
    output logic [AW-1:0] next_upc,
    output logic          halt,
    output logic          wait_stall
);

    logic [AW-1:0] upc_inc;

    // Sequential successor wraps naturally at 2^AW
    assign upc_inc = upc + AW'(1);

    // Branch resolution from the current micro-word fields
    always_comb begin
        next_upc   = upc_inc;
        halt       = 1'b0;
        wait_stall = 1'b0;
`ifdef MICRO_SEQ_CALL_EN
        push_ret   = 1'b0;
`endif
        if (bt) begin
            case (condition)
                COND_ALWAYS: begin
                    next_upc = jump_addr;
                    halt     = (jump_addr == upc);
                end
                COND_Z: begin
                    if (z_flag) next_upc = jump_addr;
                end
                COND_NZ: begin
                    if (!z_flag) next_upc = jump_addr;
                end
                default: begin
                    // COND_WAIT: either go now or stall on this word
                    if (mem_rdy) begin
                        next_upc = jump_addr;
                    end else begin
                        next_upc   = upc;
                        wait_stall = 1'b1;
                    end
                end
            endcase
        end
`ifdef MICRO_SEQ_CALL_EN
        else begin
            case (condition)
                COND_CALL: begin
                    next_upc = jump_addr;
                    push_ret = 1'b1;
                end
                COND_RET: begin
                    next_upc = ret_addr;
                end
                default: begin
                    next_upc = upc_inc;
                end
            endcase
        end
`endif
    end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer.sv
// Micro-program sequencer for the matrix-multiplication core. Owns the
// micro-PC addressing the combinational microcode, registers the control
// word for the datapath and runs a start/done handshake with the host.
// Optional feature macro: MICRO_SEQ_CALL_EN (one-entry return register
// with CALL/RET on BT=0 words).

module micro_sequencer
    import micro_pkg::*;
#(
    parameter int            AW         = DEF_AW,
    parameter int            OPW        = DEF_OPW,
    parameter logic [AW-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    micro_sequencer_if.master bus
);

    state_t          state_reg, state_next;
    logic [AW-1:0]   upc_reg,   upc_next;
    logic [OPW-1:0]  ops_q_reg, ops_q_next;
    logic            done_reg,  done_next;

    logic [AW-1:0]   next_upc;
    logic            halt;
    logic            wait_stall;

`ifdef MICRO_SEQ_CALL_EN
    logic [AW-1:0]   ret_reg;
    logic            push_ret;
`endif

    micro_next_addr #(
        .AW(AW)
    ) u_next_addr (
        .upc        (upc_reg),
        .condition  (bus.condition),
        .bt         (bus.BT),
        .jump_addr  (bus.jump_addr),
        .z_flag     (bus.z_flag),
        .mem_rdy    (bus.mem_rdy),
`ifdef MICRO_SEQ_CALL_EN
        .ret_addr   (ret_reg),
        .push_ret   (push_ret),
`endif
        .next_upc   (next_upc),
        .halt       (halt),
        .wait_stall (wait_stall)
    );

    // State, micro-PC, control word and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            upc_reg   <= '0;
            ops_q_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            upc_reg   <= upc_next;
            ops_q_reg <= ops_q_next;
            done_reg  <= done_next;
        end
    end

`ifdef MICRO_SEQ_CALL_EN
    // Return register captures the word after a CALL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_reg <= '0;
        end else if (state_reg == RUN && push_ret) begin
            ret_reg <= upc_reg + AW'(1);
        end
    end
`endif

    // Next-state, next micro-PC and control-word selection
    always_comb begin
        state_next = state_reg;
        upc_next   = upc_reg;
        ops_q_next = '0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    upc_next   = START_ADDR;
                end
            end
            RUN: begin
                ops_q_next = bus.OPs;
                if (halt) begin
                    state_next = IDLE;
                    upc_next   = '0;
                    done_next  = 1'b1;
                end else if (wait_stall) begin
                    state_next = WAIT;
                end else begin
                    upc_next = next_upc;
                end
            end
            WAIT: begin
                // ops_q stays zero so the waiting word is not re-executed
                if (bus.mem_rdy) begin
                    state_next = RUN;
                    upc_next   = bus.jump_addr;
                end
            end
            default: begin
                state_next = IDLE;
                upc_next   = '0;
            end
        endcase
    end

    assign bus.upc   = upc_reg;
    assign bus.ops_q = ops_q_reg;
    assign bus.busy  = (state_reg != IDLE);
    assign bus.done  = done_reg;

endmodule
